// File: rtl/wb_cmd_controller_if.sv
// Command/response stream plus Wishbone classic bus for wb_cmd_controller.
// The master modport is the controller; slave is the command source plus device.
interface wb_cmd_controller_if #(
   parameter int DAT_WIDTH = 8
);
   logic                 cmd_valid_i;
   logic                 cmd_ready_o;
   logic                 cmd_we_i;
   logic [DAT_WIDTH-1:0] cmd_dat_i;
   logic                 rsp_valid_o;
   logic                 rsp_ready_i;
   logic [DAT_WIDTH-1:0] rsp_dat_o;
   logic [1:0]           rsp_status_o;
   logic                 cyc_o;
   logic                 stb_o;
   logic                 we_o;
   logic [DAT_WIDTH-1:0] dat_o;
   logic                 ack_i;
   logic                 err_i;
   logic                 rty_i;
   logic [DAT_WIDTH-1:0] dat_i;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_dat_i, rsp_ready_i,
      input  ack_i, err_i, rty_i, dat_i,
      output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
      output cyc_o, stb_o, we_o, dat_o
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_dat_i, rsp_ready_i,
      output ack_i, err_i, rty_i, dat_i,
      input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
      input  cyc_o, stb_o, we_o, dat_o
   );
endinterface

// File: rtl/wb_cmd_controller.sv
// Wishbone B4 classic controller: one command in, one bus transaction (with
// retries on rty and optional timeout), one status+data response beat out.
module wb_cmd_controller #(
   parameter int DAT_WIDTH      = 8,
   parameter int MAX_RETRIES    = 3,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   wb_cmd_controller_if.master  bus,
   output logic [1:0]           state_dbg_o
);
   // Handshakes: a beat transfers on a rising edge where valid and ready are
   // both high; valid never waits on ready and the payload is held until taken.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_BACKOFF = 2'd2,
      S_RESP    = 2'd3
   } state_e;

   localparam int             TW        = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]     RETRY_MAX = 8'(MAX_RETRIES);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ERR     = 2'b01;
   localparam logic [1:0] ST_RTY_EXH = 2'b10;
   localparam logic [1:0] ST_TIMEOUT = 2'b11;

   state_e               state_q;
   logic                 cyc_q;
   logic                 we_q;
   logic [DAT_WIDTH-1:0] wdat_q;
   logic                 rsp_valid_q;
   logic [DAT_WIDTH-1:0] rsp_dat_q;
   logic [1:0]           status_q;
   logic [7:0]           retry_q;
   logic [TW-1:0]        timer_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         wdat_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         status_q    <= ST_OK;
         retry_q     <= '0;
         timer_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid_i) begin
                  we_q    <= bus.cmd_we_i;
                  wdat_q  <= bus.cmd_dat_i;
                  retry_q <= '0;
                  timer_q <= '0;
                  cyc_q   <= 1'b1;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.ack_i) begin
                  rsp_dat_q   <= we_q ? '0 : bus.dat_i;
                  status_q    <= ST_OK;
                  cyc_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else if (bus.err_i) begin
                  rsp_dat_q   <= '0;
                  status_q    <= ST_ERR;
                  cyc_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else if (bus.rty_i) begin
                  cyc_q <= 1'b0;
                  if (retry_q < RETRY_MAX) begin
                     retry_q <= retry_q + 8'd1;
                     state_q <= S_BACKOFF;
                  end else begin
                     rsp_dat_q   <= '0;
                     status_q    <= ST_RTY_EXH;
                     rsp_valid_q <= 1'b1;
                     state_q     <= S_RESP;
                  end
               end else if (TIMEOUT_CYCLES != 0 && timer_q == TO_LAST) begin
                  rsp_dat_q   <= '0;
                  status_q    <= ST_TIMEOUT;
                  cyc_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else if (timer_q != '1) begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            // A retry always restarts from an idle bus for one cycle.
            S_BACKOFF: begin
               timer_q <= '0;
               cyc_q   <= 1'b1;
               state_q <= S_REQ;
            end
            S_RESP: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  rsp_dat_q   <= '0;
                  status_q    <= ST_OK;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Every bus output decodes from registers; device responses never reach
   // an output combinationally.
   assign bus.cyc_o        = cyc_q;
   assign bus.stb_o        = cyc_q;
   assign bus.we_o         = cyc_q & we_q;
   assign bus.dat_o        = wdat_q;
   assign bus.cmd_ready_o  = (state_q == S_IDLE) & ~rst_i;
   assign bus.rsp_valid_o  = rsp_valid_q;
   assign bus.rsp_dat_o    = rsp_dat_q;
   assign bus.rsp_status_o = status_q;
   assign state_dbg_o      = state_q;
endmodule

// File: tb/tb_wb_cmd_controller.sv
// Randomized bench for wb_cmd_controller: each command gets a per-attempt
// device plan; an attempt-level model predicts pulse lengths, status and data.
module tb_wb_cmd_controller;
   localparam int W    = 8;
   localparam int MAXR = 3;
   localparam int TO   = 8;

   localparam int K_NONE = 0;
   localparam int K_ACK  = 1;
   localparam int K_ERR  = 2;
   localparam int K_RTY  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] state_dbg;

   wb_cmd_controller_if #(.DAT_WIDTH(W)) bus ();

   wb_cmd_controller #(
      .DAT_WIDTH(W),
      .MAX_RETRIES(MAXR),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus(bus),
      .state_dbg_o(state_dbg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Per-command plan: device behaviour for each bus attempt.
   int           p_kind[8];
   int           p_wait[8];
   int           p_hold;
   logic         p_we;
   logic [W-1:0] p_dat;
   logic [W-1:0] p_rd;

   logic [31:0]  exp_q[$];
   logic [1:0]   exp_status;
   logic [W-1:0] exp_data;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_dev();
      bus.ack_i = 1'b0;
      bus.err_i = 1'b0;
      bus.rty_i = 1'b0;
      bus.dat_i = '0;
   endtask

   task automatic clear_plan();
      for (int a = 0; a < 8; a++) begin
         p_kind[a] = K_ACK;
         p_wait[a] = 0;
      end
      p_hold = 0;
   endtask

   // Model: walk the attempts; each ends in ack/err/rty or runs out the timer.
   task automatic build_expect();
      exp_q.delete();
      exp_status = 2'b00;
      exp_data   = '0;
      for (int a = 0; a <= MAXR; a++) begin
         if (p_kind[a] == K_NONE || p_wait[a] >= TO) begin
            exp_q.push_back(TO);
            exp_status = 2'b11;
            return;
         end
         exp_q.push_back(p_wait[a] + 1);
         if (p_kind[a] == K_ACK) begin
            exp_status = 2'b00;
            exp_data   = p_we ? '0 : p_rd;
            return;
         end
         if (p_kind[a] == K_ERR) begin
            exp_status = 2'b01;
            return;
         end
         if (a == MAXR) begin
            exp_status = 2'b10;
            return;
         end
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      clear_dev();
      bus.cmd_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge with the controller idle.
   task automatic run_cmd();
      int           att = 0;
      int           k = 0;
      int           gap = 0;
      int           cycles = 0;
      int           kind;
      bit           in_pulse = 0;
      bit           done = 0;
      logic [31:0]  exp_len;
      logic [1:0]   got_st;
      logic [W-1:0] got_dat;

      build_expect();
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = p_we;
      bus.cmd_dat_i   = p_dat;
      check_eq("cmd_ready_idle", bus.cmd_ready_o, 1);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      bus.cmd_dat_i   = W'($urandom);
      bus.cmd_we_i    = 1'($urandom);
      check_eq("cyc_latency", bus.cyc_o, 1);

      while (!done) begin
         if (bus.cyc_o) begin
            if (!in_pulse) begin
               if (att > 0) check_eq("backoff_gap", gap, 1);
               in_pulse = 1;
               k = 0;
            end
            check_eq("stb_eq_cyc", bus.stb_o, 1);
            check_eq("we_o", bus.we_o, p_we);
            check_eq("dat_o", bus.dat_o, p_dat);
            check_eq("busy_not_ready", bus.cmd_ready_o, 0);
            check_eq("busy_no_rsp", bus.rsp_valid_o, 0);
            kind = (att < 8) ? p_kind[att] : K_NONE;
            clear_dev();
            bus.dat_i = W'($urandom);
            if (kind != K_NONE && k == p_wait[att]) begin
               bus.ack_i = (kind == K_ACK);
               bus.err_i = (kind == K_ERR);
               bus.rty_i = (kind == K_RTY);
               if (kind == K_ACK) bus.dat_i = p_rd;
            end
            k++;
         end else begin
            if (in_pulse) begin
               in_pulse = 0;
               exp_len = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
               check_eq("pulse_len", k, exp_len);
               att++;
               gap = 0;
            end
            gap++;
            // Responses while the bus is idle must be ignored.
            bus.ack_i = 1'($urandom);
            bus.err_i = 1'($urandom);
            bus.rty_i = 1'($urandom);
            bus.dat_i = W'($urandom);
            if (bus.rsp_valid_o) done = 1;
         end
         if (!done) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (cycles > 200) begin
               check_eq("cmd_bound", bus.rsp_valid_o, 1);
               pulse_reset();
               return;
            end
         end
      end

      check_eq("pulses_left", exp_q.size(), 0);
      got_st  = bus.rsp_status_o;
      got_dat = bus.rsp_dat_o;
      check_eq("rsp_status", got_st, exp_status);
      check_eq("rsp_dat", got_dat, exp_data);
      check_eq("rsp_not_ready", bus.cmd_ready_o, 0);
      for (int i = 0; i < p_hold; i++) begin
         bus.rsp_ready_i = 1'b0;
         @(posedge clk);
         @(negedge clk);
         bus.ack_i = 1'($urandom);
         bus.err_i = 1'($urandom);
         bus.rty_i = 1'($urandom);
         check_eq("hold_valid", bus.rsp_valid_o, 1);
         check_eq("hold_status", bus.rsp_status_o, got_st);
         check_eq("hold_dat", bus.rsp_dat_o, got_dat);
         check_eq("hold_not_ready", bus.cmd_ready_o, 0);
         check_eq("hold_cyc", bus.cyc_o, 0);
      end
      bus.rsp_ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
      clear_dev();
      check_eq("rsp_taken", bus.rsp_valid_o, 0);
      check_eq("ready_again", bus.cmd_ready_o, 1);
      check_eq("idle_cyc", bus.cyc_o, 0);
   endtask

   initial begin
      int r;
      rst = 1'b1;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_dat_i   = '0;
      bus.rsp_ready_i = 1'b0;
      clear_dev();
      repeat (3) @(negedge clk);
      check_eq("rst_cyc", bus.cyc_o, 0);
      check_eq("rst_stb", bus.stb_o, 0);
      check_eq("rst_we", bus.we_o, 0);
      check_eq("rst_dat_o", bus.dat_o, 0);
      check_eq("rst_rsp_valid", bus.rsp_valid_o, 0);
      check_eq("rst_rsp_dat", bus.rsp_dat_o, 0);
      check_eq("rst_status", bus.rsp_status_o, 0);
      check_eq("rst_cmd_ready", bus.cmd_ready_o, 0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_ready", bus.cmd_ready_o, 1);
      @(negedge clk);

      // Write 0xA5, ack in the first cycle.
      clear_plan();
      p_we = 1'b1; p_dat = 8'hA5; p_rd = 8'h77;
      run_cmd();

      // Read with three wait states.
      clear_plan();
      p_we = 1'b0; p_dat = 8'h11; p_rd = 8'h3C; p_wait[0] = 3;
      run_cmd();

      // rty, rty, then ack.
      clear_plan();
      p_we = 1'b0; p_dat = 8'h00; p_rd = 8'h5A;
      p_kind[0] = K_RTY; p_kind[1] = K_RTY; p_kind[2] = K_ACK;
      run_cmd();

      // rty forever: retries exhausted.
      clear_plan();
      p_we = 1'b1; p_dat = 8'hC3; p_rd = 8'h99;
      for (int a = 0; a < 8; a++) p_kind[a] = K_RTY;
      run_cmd();

      // err on a read with a slow consumer.
      clear_plan();
      p_we = 1'b0; p_dat = 8'h00; p_rd = 8'hEE; p_kind[0] = K_ERR; p_hold = 5;
      run_cmd();

      // Silent device: timeout.
      clear_plan();
      p_we = 1'b0; p_dat = 8'h42; p_rd = 8'h24; p_kind[0] = K_NONE;
      run_cmd();

      // Reset while the bus cycle is open.
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = 1'b1;
      bus.cmd_dat_i   = 8'h6D;
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("pre_rst_cyc", bus.cyc_o, 1);
      rst = 1'b1;
      #1;
      check_eq("midrst_cyc", bus.cyc_o, 0);
      check_eq("midrst_stb", bus.stb_o, 0);
      check_eq("midrst_rsp", bus.rsp_valid_o, 0);
      check_eq("midrst_ready", bus.cmd_ready_o, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("after_rst_rsp", bus.rsp_valid_o, 0);
         check_eq("after_rst_cyc", bus.cyc_o, 0);
         check_eq("after_rst_ready", bus.cmd_ready_o, 1);
      end

      // Random traffic.
      for (int n = 0; n < 80; n++) begin
         clear_plan();
         p_we   = 1'($urandom);
         p_dat  = W'($urandom);
         p_rd   = W'($urandom);
         p_hold = $urandom_range(0, 3);
         for (int a = 0; a < 8; a++) begin
            r = $urandom_range(0, 99);
            p_kind[a] = (r < 40) ? K_ACK : (r < 55) ? K_ERR : (r < 92) ? K_RTY : K_NONE;
            p_wait[a] = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 2);
         end
         run_cmd();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
